// File: rtl/map_pkg.sv
// Shared widths, query-state encoding and default starvation limit for the map ROM arbiter.
package map_pkg;

  localparam int MAP_ADDR_W     = 12;
  localparam int MAP_IDX_W      = 3;
  localparam int MAP_STARVE_LIM = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    ACK
  } q_state_e;

endpackage

// File: rtl/map_query_fsm.sv
// Game-logic query side of the map ROM arbiter: query FSM, starve counter and result registers.
// Slot stealing after STARVE_LIM lost cycles is compiled in only with MAP_ARB_STEAL_EN.
module map_query_fsm
  import map_pkg::*;
#(
  parameter int IDX_W      = MAP_IDX_W,
  parameter int STARVE_LIM = MAP_STARVE_LIM
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             disp_valid_i,
  input  logic             q_req_i,
  input  logic [IDX_W-1:0] rom_data_i,
  output logic             grant_o,
  output logic             q_ack_o,
  output logic [IDX_W-1:0] q_index_o
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  q_state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_ack_q, q_ack_d;
  logic [IDX_W-1:0] q_index_q, q_index_d;
  logic             steal;
  logic             pending;

`ifdef MAP_ARB_STEAL_EN
  assign steal = (cnt_q == CNT_W'(STARVE_LIM));
`else
  assign steal = 1'b0;
`endif

  always_comb begin
    pending   = ((state_q == IDLE) && q_req_i) || (state_q == WAIT);
    grant_o   = pending && (!disp_valid_i || steal);
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_ack_d   = 1'b0;
    q_index_d = q_index_q;
    case (state_q)
      IDLE: begin
        if (q_req_i) begin
          if (grant_o) begin
            state_d = READ;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        // A non-granted WAIT cycle is always one lost to the display path.
        if (grant_o) begin
          state_d = READ;
          cnt_d   = '0;
        end else if (cnt_q != CNT_W'(STARVE_LIM)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        q_index_d = rom_data_i;
        q_ack_d   = 1'b1;
        state_d   = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      q_ack_q   <= 1'b0;
      q_index_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_ack_q   <= q_ack_d;
      q_index_q <= q_index_d;
    end
  end

  assign q_ack_o   = q_ack_q;
  assign q_index_o = q_index_q;

endmodule

// File: rtl/map_read_arbiter.sv
// Shares the 1-cycle-latency map index ROM between the display fetch pipeline and game queries.
// Define MAP_ARB_STEAL_EN to let a starved query steal a display slot (result repeated, flagged).
module map_read_arbiter
  import map_pkg::*;
#(
  parameter int ADDR_W     = MAP_ADDR_W,
  parameter int IDX_W      = MAP_IDX_W,
  parameter int STARVE_LIM = MAP_STARVE_LIM
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              disp_valid_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_valid_o,
  output logic [IDX_W-1:0]  disp_index_o,
  output logic              disp_stolen_o,
  input  logic              q_req_i,
  input  logic [ADDR_W-1:0] q_addr_i,
  output logic              q_ack_o,
  output logic [IDX_W-1:0]  q_index_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [IDX_W-1:0]  rom_data_i
);

  logic              grant;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_stolen_q, s1_stolen_d;
  logic              disp_valid_q, disp_valid_d;
  logic              disp_stolen_q, disp_stolen_d;
  logic [IDX_W-1:0]  disp_index_q, disp_index_d;

  map_query_fsm #(
    .IDX_W      (IDX_W),
    .STARVE_LIM (STARVE_LIM)
  ) u_query_fsm (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .disp_valid_i (disp_valid_i),
    .q_req_i      (q_req_i),
    .rom_data_i   (rom_data_i),
    .grant_o      (grant),
    .q_ack_o      (q_ack_o),
    .q_index_o    (q_index_o)
  );

  always_comb begin
    // Idle cycles keep the last address so the ROM sees no needless toggling.
    rom_addr_d = rom_addr_q;
    if (grant) begin
      rom_addr_d = q_addr_i;
    end else if (disp_valid_i) begin
      rom_addr_d = disp_addr_i;
    end
    s1_valid_d = disp_valid_i;
`ifdef MAP_ARB_STEAL_EN
    s1_stolen_d = disp_valid_i && grant;
`else
    s1_stolen_d = 1'b0;
`endif
    disp_valid_d  = s1_valid_q;
    disp_stolen_d = s1_valid_q && s1_stolen_q;
    // A stolen slot leaves the index register untouched, repeating the last delivered value.
    disp_index_d  = disp_index_q;
    if (s1_valid_q && !s1_stolen_q) begin
      disp_index_d = rom_data_i;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_addr_q    <= '0;
      s1_valid_q    <= 1'b0;
      s1_stolen_q   <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_stolen_q <= 1'b0;
      disp_index_q  <= '0;
    end else begin
      rom_addr_q    <= rom_addr_d;
      s1_valid_q    <= s1_valid_d;
      s1_stolen_q   <= s1_stolen_d;
      disp_valid_q  <= disp_valid_d;
      disp_stolen_q <= disp_stolen_d;
      disp_index_q  <= disp_index_d;
    end
  end

  assign rom_addr_o    = rom_addr_d;
  assign disp_valid_o  = disp_valid_q;
  assign disp_index_o  = disp_index_q;
  assign disp_stolen_o = disp_stolen_q;

endmodule

// File: tb/tb_map_read_arbiter.sv
// Self-checking bench for map_read_arbiter: ROM model, transaction-level reference model, scenario tasks.
// Build with MAP_ARB_STEAL_EN defined to exercise slot stealing instead of the pure-contention case.
module tb_map_read_arbiter;

  localparam int AW  = 12;
  localparam int IW  = 3;
  localparam int LIM = 4;
`ifdef MAP_ARB_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          disp_valid_i = 1'b0;
  logic [AW-1:0] disp_addr_i = '0;
  logic          disp_valid_o;
  logic [IW-1:0] disp_index_o;
  logic          disp_stolen_o;
  logic          q_req_i = 1'b0;
  logic [AW-1:0] q_addr_i = '0;
  logic          q_ack_o;
  logic [IW-1:0] q_index_o;
  logic [AW-1:0] rom_addr_o;
  logic [IW-1:0] rom_data_i;

  map_read_arbiter #(.ADDR_W(AW), .IDX_W(IW), .STARVE_LIM(LIM)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .disp_valid_i(disp_valid_i), .disp_addr_i(disp_addr_i),
    .disp_valid_o(disp_valid_o), .disp_index_o(disp_index_o), .disp_stolen_o(disp_stolen_o),
    .q_req_i(q_req_i), .q_addr_i(q_addr_i), .q_ack_o(q_ack_o), .q_index_o(q_index_o),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i)
  );

  always #5 Clk = ~Clk;

  // Map ROM: one cycle read latency.
  logic [IW-1:0] mem [0:(1<<AW)-1];
  always @(posedge Clk) rom_data_i <= mem[rom_addr_o];

  typedef struct {
    int          due;
    logic [IW-1:0] idx;
    bit          stolen;
  } dexp_t;

  dexp_t dq[$];
  int checks = 0, errors = 0, cyc = 0;
  bit m_waiting = 1'b0;
  int m_lost = 0, ack_due = -1, next_sample = 0;
  logic [IW-1:0] q_pend = '0, q_exp = '0, last_idx = '0;
  logic [AW-1:0] last_rom = '0;
  bit req_active = 1'b0;
  logic [AW-1:0] req_addr = '0;
  int acks_seen = 0, stolen_seen = 0;

  // One clock cycle: drive inputs, predict from the arbitration rules, check outputs.
  task automatic step(input bit dv, input logic [AW-1:0] da, input bit rst);
    logic [AW-1:0] exp_rom;
    bit gnt;
    dexp_t e;
    disp_valid_i = dv; disp_addr_i = da;
    q_req_i = req_active; q_addr_i = req_addr; Reset_n = !rst;
    gnt = 1'b0; exp_rom = last_rom;
    if (!rst) begin
      if (!m_waiting && req_active && cyc >= next_sample) begin
        if (!dv) gnt = 1'b1;
        else begin m_waiting = 1'b1; m_lost = 0; end
      end else if (m_waiting) begin
        if (!dv || (STEAL_EN && m_lost >= LIM)) gnt = 1'b1;
        else if (m_lost < LIM) m_lost++;
      end
      if (gnt) begin
        m_waiting = 1'b0; exp_rom = req_addr;
        ack_due = cyc + 2; next_sample = cyc + 3; q_pend = mem[req_addr];
      end
      if (dv) begin
        e.due = cyc + 2;
        if (gnt) begin e.idx = last_idx; e.stolen = 1'b1; end
        else begin exp_rom = da; e.idx = mem[da]; e.stolen = 1'b0; last_idx = mem[da]; end
        dq.push_back(e);
      end
      last_rom = exp_rom;
    end
    @(negedge Clk);
    if (!rst) begin
      checks++;
      if (rom_addr_o !== exp_rom) begin
        errors++; $display("FAIL rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr_o, exp_rom);
      end
    end
    @(posedge Clk); #1; cyc++;
    if (rst) begin
      dq.delete(); m_waiting = 1'b0; ack_due = -1; next_sample = 0;
      q_exp = '0; last_idx = '0; last_rom = '0;
      checks++;
      if ({disp_valid_o, disp_index_o, disp_stolen_o, q_ack_o, q_index_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got dv=%b di=%0d ds=%b ack=%b qi=%0d exp all 0",
                 cyc, disp_valid_o, disp_index_o, disp_stolen_o, q_ack_o, q_index_o);
      end
    end else begin
      if (dq.size() > 0 && dq[0].due == cyc) begin
        e = dq.pop_front();
        checks++;
        if (disp_valid_o !== 1'b1 || disp_index_o !== e.idx || disp_stolen_o !== e.stolen) begin
          errors++;
          $display("FAIL disp_out cyc=%0d got v=%b idx=%0d st=%b exp v=1 idx=%0d st=%b",
                   cyc, disp_valid_o, disp_index_o, disp_stolen_o, e.idx, e.stolen);
        end
      end else begin
        checks++;
        if (disp_valid_o !== 1'b0 || disp_stolen_o !== 1'b0) begin
          errors++;
          $display("FAIL disp_idle cyc=%0d got v=%b st=%b exp 0", cyc, disp_valid_o, disp_stolen_o);
        end
      end
      if (ack_due == cyc) q_exp = q_pend;
      checks++;
      if (q_ack_o !== (ack_due == cyc) || q_index_o !== q_exp) begin
        errors++;
        $display("FAIL query_out cyc=%0d got ack=%b idx=%0d exp ack=%b idx=%0d",
                 cyc, q_ack_o, q_index_o, (ack_due == cyc), q_exp);
      end
    end
    if (q_ack_o) acks_seen++;
    if (disp_stolen_o) stolen_seen++;
    if (ack_due == cyc) req_active = 1'b0;
  endtask

  task automatic wait_ack(input bit dv_during, input string name);
    for (int i = 0; i < 40 && req_active; i++) step(dv_during, AW'($urandom), 1'b0);
    checks++;
    if (req_active) begin
      errors++; $display("FAIL %s_timeout cyc=%0d got no ack exp ack", name, cyc);
    end
  endtask

  task automatic test_reset();
    int acks0;
    acks0 = acks_seen;
    req_active = 1'b1; req_addr = 12'h0a5;
    for (int i = 0; i < 3; i++) step(1'b1, AW'(i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, AW'(i + 8), 1'b0);
    checks++;
    if (acks_seen != acks0) begin
      errors++; $display("FAIL reset_no_ack got acks=%0d exp 0", acks_seen - acks0);
    end
    wait_ack(1'b0, "reset_release");
  endtask

  task automatic test_display_stream();
    for (int a = 0; a < 16; a++) step(1'b1, AW'(a), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic test_blanking_query();
    int raise_c;
    step(1'b0, '0, 1'b0);
    req_active = 1'b1; req_addr = 12'h123; raise_c = cyc;
    wait_ack(1'b0, "blanking");
    checks++;
    if (q_ack_o !== 1'b1 || q_index_o !== 3'd5 || cyc - raise_c != 2) begin
      errors++;
      $display("FAIL blanking_ack got ack=%b idx=%0d lat=%0d exp ack=1 idx=5 lat=2",
               q_ack_o, q_index_o, cyc - raise_c);
    end
    step(1'b0, '0, 1'b0);
    checks++;
    if (q_ack_o !== 1'b0) begin
      errors++; $display("FAIL blanking_ack_width got ack=%b exp 0", q_ack_o);
    end
  endtask

`ifndef MAP_ARB_STEAL_EN
  task automatic test_contention();
    int acks0, g;
    step(1'b0, '0, 1'b0);
    req_active = 1'b1; req_addr = AW'($urandom);
    acks0 = acks_seen;
    for (int i = 0; i < 100; i++) step(1'b1, AW'($urandom), 1'b0);
    checks++;
    if (acks_seen != acks0 || !req_active) begin
      errors++; $display("FAIL contention_no_grant got acks=%0d exp 0", acks_seen - acks0);
    end
    g = cyc;
    step(1'b0, '0, 1'b0);
    wait_ack(1'b1, "contention");
    checks++;
    if (cyc - g != 2) begin
      errors++; $display("FAIL contention_latency got %0d exp 2", cyc - g);
    end
  endtask
`else
  task automatic test_steal();
    int raise_c, st0;
    step(1'b0, '0, 1'b0);
    st0 = stolen_seen;
    req_active = 1'b1; req_addr = AW'($urandom); raise_c = cyc;
    wait_ack(1'b1, "steal");
    checks++;
    if (cyc - raise_c != LIM + 3 || stolen_seen - st0 != 1) begin
      errors++;
      $display("FAIL steal_timing got lat=%0d stolen=%0d exp lat=%0d stolen=1",
               cyc - raise_c, stolen_seen - st0, LIM + 3);
    end
    for (int i = 0; i < 3; i++) step(1'b1, AW'($urandom), 1'b0);
  endtask
`endif

  task automatic test_reset_mid_query();
    int acks0;
    step(1'b0, '0, 1'b0);
    req_active = 1'b1; req_addr = AW'($urandom);
    acks0 = acks_seen;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, AW'($urandom), 1'b1);
    checks++;
    if (acks_seen != acks0) begin
      errors++; $display("FAIL mid_query_reset got acks=%0d exp 0", acks_seen - acks0);
    end
    wait_ack(1'b0, "mid_query_reserve");
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if (!req_active && $urandom_range(0, 3) == 0) begin
        req_active = 1'b1; req_addr = AW'($urandom);
      end
      step($urandom_range(0, 9) < 7, AW'($urandom), $urandom_range(0, 249) == 0);
    end
    wait_ack(1'b0, "random_drain");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = IW'($urandom);
    for (int i = 0; i < 16; i++) mem[i] = IW'(i);
    mem[12'h123] = 3'd5;
    test_reset();
    test_display_stream();
    test_blanking_query();
`ifndef MAP_ARB_STEAL_EN
    test_contention();
`else
    test_steal();
`endif
    test_reset_mid_query();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
